// File: rtl/fsm_ring_pkg.sv
// Shared types and ring-step helpers for the fsm_ring sequencer.
package fsm_ring_pkg;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_BWD = 1'b1
   } dir_e;

   // Widest state encoding needed for the 256-state upper limit.
   localparam int ST_MAX_W = 8;
   typedef logic [ST_MAX_W-1:0] ring_st_t;

   function automatic ring_st_t next_state(ring_st_t st, dir_e dir, int unsigned n);
      ring_st_t last;
      last = ring_st_t'(n - 1);
      if (dir == DIR_BWD)
         return (st == '0) ? last : st - ring_st_t'(1);
      else
         return (st == last) ? '0 : st + ring_st_t'(1);
   endfunction

   function automatic logic is_wrap(ring_st_t st, dir_e dir, int unsigned n);
      if (dir == DIR_FWD)
         return st == ring_st_t'(n - 1);
      else
         return st == '0;
   endfunction

endpackage

// File: rtl/fsm_ring_if.sv
// Control/status bundle of the ring sequencer; master drives, slave is the sequencer.
interface fsm_ring_if
   import fsm_ring_pkg::*;
#(
   parameter int NUM_STATES = 5,
   parameter int WRAP_CNT_W = 8,
   parameter int TIMEOUT_W  = 8
);
   localparam int STW = ($clog2(NUM_STATES) > 1) ? $clog2(NUM_STATES) : 1;

   logic                  en;
   logic [NUM_STATES-1:0] adv;
   logic                  dir;
   logic                  load;
   logic [STW-1:0]        load_st;
   logic [TIMEOUT_W-1:0]  timeout;
   logic [STW-1:0]        y;
   logic [NUM_STATES-1:0] onehot;
   logic                  wrap;
   logic [WRAP_CNT_W-1:0] wrap_cnt;
   logic                  to_fired;

   modport master (
      output en, adv, dir, load, load_st, timeout,
      input  y, onehot, wrap, wrap_cnt, to_fired
   );

   modport slave (
      input  en, adv, dir, load, load_st, timeout,
      output y, onehot, wrap, wrap_cnt, to_fired
   );
endinterface

// File: rtl/fsm_ring_dwell.sv
// Dwell counter and timeout compare; only instantiated when FSM_RING_TIMEOUT_EN is defined.
module fsm_ring_dwell
   import fsm_ring_pkg::*;
#(
   parameter int TIMEOUT_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 adv_cur,
   input  logic                 load,
   input  logic                 step,
   input  logic [TIMEOUT_W-1:0] timeout,
   output logic                 fire
);
   logic [TIMEOUT_W-1:0] dwell_q, dwell_d;

   always_comb begin
      fire    = en && !adv_cur && (timeout != '0) &&
                (dwell_q == timeout - TIMEOUT_W'(1));
      dwell_d = dwell_q;
      if (load || step)
         dwell_d = '0;
      else if (en && (dwell_q != '1))
         dwell_d = dwell_q + TIMEOUT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset)
         dwell_q <= '0;
      else
         dwell_q <= dwell_d;
   end
endmodule

// File: rtl/fsm_ring.sv
// Parametrised N-state ring sequencer with load, direction, wrap count and
// optional dwell timeout (enabled by defining FSM_RING_TIMEOUT_EN).
//   state            | meaning
//   0..NUM_STATES-1  | ring position k, advances on adv[k] (or a timeout)
module fsm_ring
   import fsm_ring_pkg::*;
#(
   parameter int NUM_STATES = 5,
   parameter int WRAP_CNT_W = 8,
   parameter int TIMEOUT_W  = 8
) (
   input  logic     clock,
   input  logic     reset,
   fsm_ring_if.slave bus
);
   localparam int STW = ($clog2(NUM_STATES) > 1) ? $clog2(NUM_STATES) : 1;

   logic [STW-1:0]        y_q, y_d, y_nxt;
   logic                  wrap_q, wrap_d;
   logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic                  adv_cur, fire, step, load_ok, at_wrap;

   always_comb begin
      adv_cur    = bus.adv[y_q];
      load_ok    = int'(bus.load_st) < NUM_STATES;
      step       = !bus.load && bus.en && (adv_cur || fire);
      y_nxt      = STW'(next_state(ring_st_t'(y_q), dir_e'(bus.dir), NUM_STATES));
      at_wrap    = is_wrap(ring_st_t'(y_q), dir_e'(bus.dir), NUM_STATES);
      y_d        = y_q;
      wrap_d     = 1'b0;
      wrap_cnt_d = wrap_cnt_q;
      // An out-of-range load still consumes the cycle: no advance happens.
      if (bus.load) begin
         if (load_ok)
            y_d = bus.load_st;
      end else if (step) begin
         y_d    = y_nxt;
         wrap_d = at_wrap;
         if (at_wrap)
            wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         y_q        <= '0;
         wrap_q     <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         y_q        <= y_d;
         wrap_q     <= wrap_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   for (genvar k = 0; k < NUM_STATES; k++) begin : g_onehot
      assign bus.onehot[k] = (y_q == STW'(k));
   end

   assign bus.y        = y_q;
   assign bus.wrap     = wrap_q;
   assign bus.wrap_cnt = wrap_cnt_q;

`ifdef FSM_RING_TIMEOUT_EN
   logic to_fired_q, to_fired_d;

   fsm_ring_dwell #(.TIMEOUT_W(TIMEOUT_W)) u_dwell (
      .clock   (clock),
      .reset   (reset),
      .en      (bus.en),
      .adv_cur (adv_cur),
      .load    (bus.load),
      .step    (step),
      .timeout (bus.timeout),
      .fire    (fire)
   );

   always_comb to_fired_d = step && fire;

   always_ff @(posedge clock) begin
      if (reset)
         to_fired_q <= 1'b0;
      else
         to_fired_q <= to_fired_d;
   end

   assign bus.to_fired = to_fired_q;
`else
   logic [TIMEOUT_W-1:0] unused_timeout;

   assign unused_timeout = bus.timeout;
   assign fire           = 1'b0;
   assign bus.to_fired   = 1'b0;
`endif

endmodule
